// File: rtl/battlefront_calc.sv
// battlefront_calc: per-tick battle scheduler computing fronts, move strobe, summed damage and damage strobe
module battlefront_calc #(
  parameter int NSLOT     = 4,
  parameter int TICK_DIV  = 1000000,
  parameter int FIELD_MAX = 511
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [9*NSLOT-1:0] enemy_pos,
  input  logic [8*NSLOT-1:0] enemy_dmg,
  input  logic [NSLOT-1:0]   enemy_dead,
  input  logic [9*NSLOT-1:0] player_pos,
  input  logic [8*NSLOT-1:0] player_dmg,
  input  logic [NSLOT-1:0]   player_dead,
  output logic               move_scen,
  output logic               damage_scen,
  output logic [8:0]         enemy_front,
  output logic [8:0]         player_front,
  output logic [7:0]         enemy_dmg_in,
  output logic [7:0]         player_dmg_in,
  output logic               busy
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = NSLOT > 1 ? $clog2(NSLOT) : 1;
  typedef enum logic [2:0] {IDLE, SCAN, MOVE, SETTLE, SUM, HIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [8:0] mn, mx, mn_nx, mx_nx, ppos, epos;
  logic [7:0] pdsum, edsum, pd_nx, ed_nx, pdm, edm;
  logic tick, last, pdead, edead;
  function automatic logic [7:0] sat(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hff : s[7:0];
  endfunction
  assign tick  = cnt == CW'(TICK_DIV - 1);
  assign last  = idx == IW'(NSLOT - 1);
  assign ppos  = player_pos[9*idx +: 9];
  assign epos  = enemy_pos[9*idx +: 9];
  assign pdm   = player_dmg[8*idx +: 8];
  assign edm   = enemy_dmg[8*idx +: 8];
  assign pdead = player_dead[idx];
  assign edead = enemy_dead[idx];
  assign mn_nx = (!pdead && ppos < mn) ? ppos : mn;
  assign mx_nx = (!edead && epos > mx) ? epos : mx;
  assign pd_nx = pdead ? pdsum : sat(pdsum, pdm);
  assign ed_nx = edead ? edsum : sat(edsum, edm);
  assign move_scen   = state == MOVE;
  assign damage_scen = state == HIT;
  assign busy        = state != IDLE;
  // free-running tick divider; a tick arriving while busy is simply ignored by the FSM
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next-state sequencing through scan, move, settle, sum, hit
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = tick ? SCAN : IDLE;
      SCAN:    state_nx = last ? MOVE : SCAN;
      MOVE:    state_nx = SETTLE;
      SETTLE:  state_nx = SUM;
      SUM:     state_nx = last ? HIT : SUM;
      HIT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // accumulators and registered fronts/damage; the last slot's value is folded in as it is latched
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      idx           <= '0;
      mn            <= 9'(FIELD_MAX);
      mx            <= '0;
      pdsum         <= '0;
      edsum         <= '0;
      enemy_front   <= 9'(FIELD_MAX);
      player_front  <= '0;
      enemy_dmg_in  <= '0;
      player_dmg_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          idx <= '0;
          mn  <= 9'(FIELD_MAX);
          mx  <= '0;
        end
        SCAN: begin
          mn  <= mn_nx;
          mx  <= mx_nx;
          idx <= last ? '0 : idx + 1'b1;
          if (last) begin
            enemy_front  <= mn_nx;
            player_front <= mx_nx;
          end
        end
        SETTLE: begin
          idx   <= '0;
          pdsum <= '0;
          edsum <= '0;
        end
        SUM: begin
          pdsum <= pd_nx;
          edsum <= ed_nx;
          idx   <= last ? '0 : idx + 1'b1;
          if (last) begin
            enemy_dmg_in  <= pd_nx;
            player_dmg_in <= ed_nx;
          end
        end
        HIT: begin
          enemy_dmg_in  <= '0;
          player_dmg_in <= '0;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_battlefront_calc.sv
// tb_battlefront_calc: scoreboard bench for battlefront_calc with TICK_DIV=20, NSLOT=4
module tb_battlefront_calc;
  localparam int P = 20;
  logic clk = 0, rst = 1;
  logic [8:0] ep[4], pp[4];
  logic [7:0] ed[4], pd[4];
  logic [3:0] edead, pdead;
  logic move_scen, damage_scen, busy;
  logic [8:0] enemy_front, player_front;
  logic [7:0] enemy_dmg_in, player_dmg_in;
  int total = 0, bad = 0, cyc = 0;
  typedef struct {int a; int b;} pair_t;
  pair_t q_mv[$], q_hit[$];
  battlefront_calc #(.NSLOT(4), .TICK_DIV(P), .FIELD_MAX(511)) dut (
    .clk(clk), .reset(rst),
    .enemy_pos({ep[3], ep[2], ep[1], ep[0]}), .enemy_dmg({ed[3], ed[2], ed[1], ed[0]}), .enemy_dead(edead),
    .player_pos({pp[3], pp[2], pp[1], pp[0]}), .player_dmg({pd[3], pd[2], pd[1], pd[0]}), .player_dead(pdead),
    .move_scen(move_scen), .damage_scen(damage_scen), .enemy_front(enemy_front), .player_front(player_front),
    .enemy_dmg_in(enemy_dmg_in), .player_dmg_in(player_dmg_in), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  // cycle count since reset release mirrors the divider phase
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  // timing checks every cycle plus scoreboard pops on each strobe
  always @(negedge clk) begin
    if (!rst) begin
      automatic bit em = cyc >= P + 4 && cyc % P == 4;
      automatic bit eh = cyc >= P + 10 && cyc % P == 10;
      automatic bit eb = cyc >= P && cyc % P <= 10;
      automatic pair_t x;
      chk("move_t", move_scen, em);
      chk("dmg_t", damage_scen, eh);
      chk("busy_t", busy, eb);
      if (!damage_scen) begin
        chk("edi_zero", enemy_dmg_in, 0);
        chk("pdi_zero", player_dmg_in, 0);
      end
      if (move_scen) begin
        if (q_mv.size() == 0) chk("mv_q", 0, 1);
        else begin
          x = q_mv.pop_front();
          chk("enemy_front", enemy_front, x.a);
          chk("player_front", player_front, x.b);
        end
      end
      if (damage_scen) begin
        if (q_hit.size() == 0) chk("hit_q", 0, 1);
        else begin
          x = q_hit.pop_front();
          chk("enemy_dmg_in", enemy_dmg_in, x.a);
          chk("player_dmg_in", player_dmg_in, x.b);
        end
      end
    end
  end
  task automatic wait_phase(input int m);
    for (int k = 0; k < 4 * P; k++) begin
      @(negedge clk);
      if (cyc % P == m) return;
    end
    chk("phase_timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "phase wait expired");
  endtask
  task automatic push_exp();
    automatic int ef = 511, pf = 0, ps = 0, es = 0;
    for (int i = 0; i < 4; i++) begin
      if (!pdead[i]) begin
        ef = pp[i] < ef ? pp[i] : ef;
        ps += pd[i];
      end
      if (!edead[i]) begin
        pf = ep[i] > pf ? ep[i] : pf;
        es += ed[i];
      end
    end
    q_mv.push_back('{ef, pf});
    q_hit.push_back('{ps > 255 ? 255 : ps, es > 255 ? 255 : es});
  endtask
  task automatic load(input int p0, p1, p2, p3, input logic [3:0] pdd, input int e0, e1, e2, e3, input logic [3:0] edd,
                      input int pd0, pd1, pd2, pd3, input int ed0, ed1, ed2, ed3);
    wait_phase(12);
    pp = '{9'(p0), 9'(p1), 9'(p2), 9'(p3)};
    ep = '{9'(e0), 9'(e1), 9'(e2), 9'(e3)};
    pd = '{8'(pd0), 8'(pd1), 8'(pd2), 8'(pd3)};
    ed = '{8'(ed0), 8'(ed1), 8'(ed2), 8'(ed3)};
    pdead = pdd;
    edead = edd;
    push_exp();
  endtask
  initial begin
    pp = '{default: 0}; ep = '{default: 0}; pd = '{default: 0}; ed = '{default: 0};
    pdead = '1; edead = '1;
    repeat (3) @(negedge clk);
    chk("rst_ef", enemy_front, 511);
    chk("rst_pf", player_front, 0);
    chk("rst_busy", busy, 0);
    rst = 0;
    load(300, 250, 10, 0, 4'b1100, 40, 120, 0, 0, 4'b1100, 1, 2, 3, 4, 5, 6, 7, 8);
    load(7, 8, 9, 10, 4'b1111, 1, 2, 3, 4, 4'b1111, 9, 9, 9, 9, 9, 9, 9, 9);
    load(100, 90, 80, 70, 4'b1000, 5, 6, 7, 8, 4'b1110, 8'h80, 8'h80, 8'h40, 8'h10, 8'h20, 8'h40, 0, 0);
    load(400, 0, 511, 3, 4'b0010, 50, 60, 100, 70, 4'b0000, 255, 0, 1, 0, 3, 4, 5, 6);
    wait_phase(3);
    ep[2] = 9'd200;
    for (int r = 0; r < 3; r++)
      load($urandom_range(511), $urandom_range(511), $urandom_range(511), $urandom_range(511), 4'($urandom),
           $urandom_range(511), $urandom_range(511), $urandom_range(511), $urandom_range(511), 4'($urandom),
           $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255),
           $urandom_range(255), $urandom_range(255), $urandom_range(255), $urandom_range(255));
    load(20, 30, 40, 50, 4'b0000, 60, 70, 80, 90, 4'b0000, 50, 50, 50, 50, 60, 60, 60, 60);
    wait_phase(8);
    #2 rst = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dmg", damage_scen, 0);
    chk("mid_rst_move", move_scen, 0);
    chk("mid_rst_ef", enemy_front, 511);
    chk("mid_rst_pf", player_front, 0);
    chk("mid_rst_edi", enemy_dmg_in, 0);
    chk("mid_rst_pdi", player_dmg_in, 0);
    void'(q_hit.pop_back());
    repeat (2) @(negedge clk);
    chk("held_rst_dmg", damage_scen, 0);
    #2 rst = 0;
    load(300, 250, 10, 0, 4'b1100, 40, 120, 0, 0, 4'b1100, 1, 2, 3, 4, 5, 6, 7, 8);
    for (int k = 0; k < 4 * P && (q_mv.size() != 0 || q_hit.size() != 0); k++) @(negedge clk);
    chk("drain", q_mv.size() + q_hit.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/battlefront_calc.md
Name: battlefront_calc

Overview:
- Battle scheduler that sits directly upstream of the enemy and player unit slots.
- On each game tick it scans all slots, computes the battlefront each side sees, and issues one move strobe.
- It then sums the attack damage each side dealt and delivers it to the opposing side with a damage strobe.
- Enemies advance toward increasing position; players advance toward decreasing position.

Parameters:
- NSLOT, 4, number of enemy slots and number of player slots (one each per index).
- TICK_DIV, 1000000, clk cycles per game tick; must exceed 2*NSLOT+4.
- FIELD_MAX, 511, position reported to enemies when no player is alive.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enemy_pos  in  9*NSLOT  enemy positions; slot i at bits [9i+8:9i].
- enemy_dmg  in  8*NSLOT  enemy damageOut values; slot i at [8i+7:8i].
- enemy_dead  in  NSLOT  1 = slot empty or dead.
- player_pos  in  9*NSLOT  player positions.
- player_dmg  in  8*NSLOT  player damageOut values.
- player_dead  in  NSLOT  1 = slot empty or dead.
- move_scen  out  1  one-cycle move strobe to all unit slots.
- damage_scen  out  1  one-cycle damage strobe to all unit slots.
- enemy_front  out  9  unitFront for enemies: nearest alive player position.
- player_front  out  9  unitFront for players: farthest alive enemy position.
- enemy_dmg_in  out  8  damage applied to each enemy, equal to the sum of player damage.
- player_dmg_in  out  8  damage applied to each player, equal to the sum of enemy damage.
- busy  out  1  1 while FSM is not in IDLE.

Behaviour:
- Reset (async, active-high): all outputs 0 except enemy_front=FIELD_MAX; tick counter=0; FSM=IDLE.
- Tick counter: counts 0..TICK_DIV-1 and wraps, free-running. Wrap produces a tick pulse.
- A tick seen outside IDLE is dropped. The counter is not stalled.
- FSM states: IDLE, SCAN, MOVE, SETTLE, SUM, HIT.
- IDLE: on tick, go to SCAN. Set the scan index to 0. Set the min accumulator to FIELD_MAX and the max accumulator to 0.
- SCAN: one slot per cycle for NSLOT cycles.
  - If player_dead[i]=0, min = min(min, player_pos[i]).
  - If enemy_dead[i]=0, max = max(max, enemy_pos[i]).
  - After slot NSLOT-1, go to MOVE.
- MOVE (1 cycle):
  - Register enemy_front=min and player_front=max; these are valid in this cycle and stay valid until the next MOVE.
  - move_scen=1 for exactly this cycle.
  - Go to SETTLE.
- SETTLE (1 cycle): move_scen=0. Lets units register damageOut produced on the move edge. Clear both sums to 0. Go to SUM.
- SUM: one slot per cycle for NSLOT cycles.
  - pdsum += player_dmg[i] if player_dead[i]=0.
  - edsum += enemy_dmg[i] if enemy_dead[i]=0.
  - Addition saturates at 255: a 9-bit add whose result is clamped to 255 if bit 8 is set.
  - After slot NSLOT-1, go to HIT.
- HIT (1 cycle):
  - enemy_dmg_in=pdsum and player_dmg_in=edsum.
  - damage_scen=1 for exactly this cycle.
  - Next cycle: damage_scen=0, both dmg_in outputs return to 0, FSM returns to IDLE.
- Latency: tick → move_scen is NSLOT+1 cycles; move_scen → damage_scen is NSLOT+2 cycles.
- move_scen and damage_scen are never high together.
- No alive players: enemy_front=FIELD_MAX. No alive enemies: player_front=0.
- Slot inputs may change during SCAN/SUM. Each slot is sampled only in the cycle its index is visited.
- Reset mid-sequence: immediate return to reset values; no strobe is emitted afterwards until a fresh tick.

Test Plan:
- TICK_DIV=20, NSLOT=4; release reset; wait for tick → move_scen high exactly at tick+5. damage_scen high exactly at tick+11. Each is 1 cycle wide. busy low otherwise.
- Players alive at 300, 250, dead slot at 10; enemies alive at 40, 120 → enemy_front=250 and player_front=120 in the MOVE cycle.
- All player_dead=1 and all enemy_dead=1 → enemy_front=511, player_front=0, both dmg_in=0 at HIT.
- Player dmg 0x80, 0x80, 0x40 alive; enemy dmg 0x20 alive and 0x40 dead → enemy_dmg_in=255 (saturated), player_dmg_in=0x20. Both are 0 the cycle after HIT.
- Assert reset during SUM → all outputs to reset values immediately; no damage_scen; next strobe pair follows the next tick.
- Slot 2 enemy_pos changes from 100 to 200 after SCAN has passed slot 2 → player_front reflects 100.
